hsv_rgb_pwm: RTL and testbench
==============================

Name: hsv_rgb_pwm

Overview:
Consumer end of the HSV control interface. Takes the Hue/Saturation/Value triplet from the button/switch controller and converts it to 8-bit RGB with a multi-cycle FSM. Drives three PWM outputs for the board's RGB LED. It sits between the HSV input controller and the LED pins.

Parameters:
PWM_DIV, 1, clock enables per PWM counter step; must be 1 or more. PWM period = 255*PWM_DIV clocks.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hue  in  9  hue in degrees, nominal 0..359
saturation  in  9  saturation in percent, nominal 0..100
value  in  9  value in percent, nominal 0..100
red  out  8  converted red level
green  out  8  converted green level
blue  out  8  converted blue level
rgb_valid  out  1  one-cycle pulse when red/green/blue update
busy  out  1  high while the conversion FSM is not IDLE
led_r  out  1  red PWM output
led_g  out  1  green PWM output
led_b  out  1  blue PWM output

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is asynchronous and active-high.
- While reset is high, everything is forced to 0: all outputs, FSM state (IDLE), the shadow copies of hue/saturation/value, the pending duties, the active duties and the PWM counter. A reset mid-conversion aborts it; red/green/blue stay 0.
- IDLE: each cycle, compare the inputs against the shadow copies. If any differs, latch the inputs into the shadows, assert busy, and go to CLAMP. This latch edge is edge 0.
- Input changes while busy are ignored. On return to IDLE the compare runs again, so the final input value is always converted.
- CLAMP (edge 1):
  - h = hue-360 if hue>=360, else hue. Result is 0..359.
  - s = min(saturation,100); v = min(value,100).
  - region = h/60 (0..5) from a comparator chain; rem = h-60*region (0..59).
- SCALE (edge 2): vmax = (v*255)/100, truncated, 8 bits.
- SPAN (edge 3):
  - vmin = (vmax*(100-s))/100.
  - delta = vmax-vmin.
  - up = vmin + (delta*rem)/60; dn = vmax - (delta*rem)/60. The intermediate product is 14 bits.
- MIX (edge 4): red/green/blue are registered by region, then the FSM returns to IDLE, rgb_valid pulses for one cycle and busy drops. Region mapping (R,G,B):
  - 0: vmax, up, vmin
  - 1: dn, vmax, vmin
  - 2: vmin, vmax, up
  - 3: vmin, dn, vmax
  - 4: up, vmin, vmax
  - 5: vmax, vmin, dn
- Latency: 4 clocks from the capture edge to rgb_valid. All divisions truncate.
- PWM counter:
  - Counts 0..254 and wraps to 0. It advances once every PWM_DIV clocks.
  - New red/green/blue values are copied into pending duties when rgb_valid fires.
  - Pending duties are loaded into the active duties only when the counter wraps to 0, so no period is ever glitched.
  - led_x = (cnt < active_duty_x). Duty 0 means always off; duty 255 means always on.
- If an rgb_valid pulse and a wrap land on the same cycle, the wrap loads the old pending value. The new value takes effect at the next wrap.

Optional Feature:
HSV_GAMMA_EN
- Defined: adds a GAMMA state after MIX that applies x' = (x*x)/255 to each channel. red/green/blue report the corrected values. Latency becomes 5 clocks.
- Undefined: linear output, 4-clock latency, no extra state.

Decomposition:
- Package hsv_pkg holds:
  - the FSM state enum (IDLE, CLAMP, SCALE, SPAN, MIX, GAMMA)
  - constants HUE_MAX=359, HUE_WRAP=360, PCT_MAX=100, SECTOR=60, PWM_TOP=254
- One sub-module, rgb_pwm_channel, instantiated three times. It holds the pending and active duty registers and the compare, and shares the counter and wrap strobe.

Test Plan:
- After reset, apply H=0,S=100,V=100 -> rgb_valid exactly 4 clocks after the capture edge; RGB=255,0,0. led_r stays high for the whole period; led_g and led_b stay low.
- H=120,S=100,V=100 -> RGB=0,255,0. H=30,S=100,V=100 -> RGB=255,127,0.
- S=0,V=50, hue swept 0..359 -> RGB=127,127,127 for every hue. led_r is high for 127 of every 255 counter steps; check with PWM_DIV=1 and PWM_DIV=4.
- Out-of-range inputs H=400,S=150,V=200 -> treated as 40,100,100 -> RGB=255,170,0.
- Change hue on edge 2 of a conversion -> first result matches the old input, then an automatic second conversion matches the new input. Assert reset mid-SPAN -> all outputs 0, no rgb_valid.
- With HSV_GAMMA_EN, H=0,S=0,V=50 -> RGB=63,63,63, latency 5. An rgb_valid landing mid-period changes the led outputs only after the next wrap.

Source files
------------

// File: rtl/hsv_rgb_pwm_pkg.sv
// Shared types and constants for the HSV-to-RGB converter and its PWM driver.
// Package: hsv_pkg (state enum, range constants, 8-bit gamma helper).
package hsv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLAMP = 3'd1,
        SCALE = 3'd2,
        SPAN  = 3'd3,
        MIX   = 3'd4,
        GAMMA = 3'd5
    } hsv_state_t;

    localparam int unsigned HUE_MAX  = 359;
    localparam int unsigned HUE_WRAP = 360;
    localparam int unsigned PCT_MAX  = 100;
    localparam int unsigned SECTOR   = 60;
    localparam int unsigned PWM_TOP  = 254;

    // Square-law correction: x' = (x*x)/255, truncated.
    function automatic logic [7:0] gamma8(input logic [7:0] x);
        logic [15:0] sq;
        sq = {8'd0, x} * {8'd0, x};
        return 8'(sq / 16'd255);
    endfunction

endpackage

// File: rtl/hsv_rgb_pwm_channel.sv
// One PWM colour channel: pending/active duty registers and the level compare.
// The active duty only changes on the shared wrap strobe, so a period is never cut short.
module rgb_pwm_channel (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    input  logic       load,
    input  logic       wrap,
    input  logic [7:0] cnt,
    output logic       led
);

    logic [7:0] pending;
    logic [7:0] active;

    // Capture new duty on load; promote pending to active at the period boundary.
    // Both use pre-edge values, so a load coinciding with a wrap lands one period later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 8'd0;
            active  <= 8'd0;
        end else begin
            if (load) begin
                pending <= duty;
            end
            if (wrap) begin
                active <= pending;
            end
        end
    end

    // Counter tops out at 254, so duty 255 is solid on and duty 0 solid off.
    assign led = (cnt < active);

endmodule

// File: rtl/hsv_rgb_pwm.sv
// HSV to 8-bit RGB converter (multi-cycle FSM) driving three PWM LED outputs.
// Optional build macro HSV_GAMMA_EN: adds a GAMMA state applying (x*x)/255 per channel,
// stretching conversion latency from 4 to 5 clocks.
//
// state | meaning
// IDLE  | watch inputs against shadow copies, latch and start on any change
// CLAMP | wrap hue, saturate s/v, split hue into 60-degree region and remainder
// SCALE | vmax = v*255/100
// SPAN  | vmin, and ramp-up/ramp-down levels within the region
// MIX   | route vmax/vmin/up/dn to R/G/B by region
// GAMMA | square-law correction (HSV_GAMMA_EN builds only)
module hsv_rgb_pwm
    import hsv_pkg::*;
#(
    parameter int unsigned PWM_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hue,
    input  logic [8:0] saturation,
    input  logic [8:0] value,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       rgb_valid,
    output logic       busy,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    hsv_state_t state;

    logic [8:0] hue_sh;
    logic [8:0] sat_sh;
    logic [8:0] val_sh;

    logic [2:0] region;
    logic [5:0] rem;
    logic [6:0] sat_c;
    logic [6:0] val_c;
    logic [7:0] vmax;
    logic [7:0] vmin;
    logic [7:0] up;
    logic [7:0] dn;

`ifdef HSV_GAMMA_EN
    logic [7:0] lin_r;
    logic [7:0] lin_g;
    logic [7:0] lin_b;
`endif

    logic [8:0] h_w;
    logic [8:0] base_w;
    logic [2:0] region_w;
    logic [5:0] rem_w;
    logic [6:0] s_w;
    logic [6:0] v_w;
    logic [7:0] vmax_w;
    logic [7:0] vmin_w;
    logic [7:0] delta_w;
    logic [13:0] prod_w;
    logic [7:0] frac_w;
    logic [7:0] up_w;
    logic [7:0] dn_w;
    logic [7:0] mix_r_w;
    logic [7:0] mix_g_w;
    logic [7:0] mix_b_w;
    logic       in_changed;

    assign in_changed = (hue != hue_sh) || (saturation != sat_sh) || (value != val_sh);
    assign busy       = (state != IDLE);

    // Hue wrap, s/v saturation and region split via a comparator chain.
    always_comb begin
        h_w = (hue_sh >= 9'(HUE_WRAP)) ? (hue_sh - 9'(HUE_WRAP)) : hue_sh;
        s_w = (sat_sh > 9'(PCT_MAX)) ? 7'(PCT_MAX) : sat_sh[6:0];
        v_w = (val_sh > 9'(PCT_MAX)) ? 7'(PCT_MAX) : val_sh[6:0];
        region_w = 3'd0;
        base_w   = 9'd0;
        if (h_w >= 9'(5 * SECTOR)) begin
            region_w = 3'd5;
            base_w   = 9'(5 * SECTOR);
        end else if (h_w >= 9'(4 * SECTOR)) begin
            region_w = 3'd4;
            base_w   = 9'(4 * SECTOR);
        end else if (h_w >= 9'(3 * SECTOR)) begin
            region_w = 3'd3;
            base_w   = 9'(3 * SECTOR);
        end else if (h_w >= 9'(2 * SECTOR)) begin
            region_w = 3'd2;
            base_w   = 9'(2 * SECTOR);
        end else if (h_w >= 9'(SECTOR)) begin
            region_w = 3'd1;
            base_w   = 9'(SECTOR);
        end
        rem_w = 6'(h_w - base_w);
    end

    // Brightness scale: percent to 0..255, truncated.
    always_comb begin
        vmax_w = 8'(({8'd0, val_c} * 15'd255) / 15'd100);
    end

    // Floor level and the linear ramp inside the current 60-degree region.
    always_comb begin
        vmin_w  = 8'(({7'd0, vmax} * {8'd0, 7'(PCT_MAX) - sat_c}) / 15'd100);
        delta_w = vmax - vmin_w;
        prod_w  = {6'd0, delta_w} * {8'd0, rem};
        frac_w  = 8'(prod_w / 14'(SECTOR));
        up_w    = vmin_w + frac_w;
        dn_w    = vmax - frac_w;
    end

    // Region to channel routing.
    always_comb begin
        mix_r_w = vmax;
        mix_g_w = vmin;
        mix_b_w = dn;
        case (region)
            3'd0: begin mix_r_w = vmax; mix_g_w = up;   mix_b_w = vmin; end
            3'd1: begin mix_r_w = dn;   mix_g_w = vmax; mix_b_w = vmin; end
            3'd2: begin mix_r_w = vmin; mix_g_w = vmax; mix_b_w = up;   end
            3'd3: begin mix_r_w = vmin; mix_g_w = dn;   mix_b_w = vmax; end
            3'd4: begin mix_r_w = up;   mix_g_w = vmin; mix_b_w = vmax; end
            default: begin mix_r_w = vmax; mix_g_w = vmin; mix_b_w = dn; end
        endcase
    end

    // Conversion sequencer: one pipeline stage per state, inputs ignored while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hue_sh    <= 9'd0;
            sat_sh    <= 9'd0;
            val_sh    <= 9'd0;
            region    <= 3'd0;
            rem       <= 6'd0;
            sat_c     <= 7'd0;
            val_c     <= 7'd0;
            vmax      <= 8'd0;
            vmin      <= 8'd0;
            up        <= 8'd0;
            dn        <= 8'd0;
            red       <= 8'd0;
            green     <= 8'd0;
            blue      <= 8'd0;
            rgb_valid <= 1'b0;
`ifdef HSV_GAMMA_EN
            lin_r     <= 8'd0;
            lin_g     <= 8'd0;
            lin_b     <= 8'd0;
`endif
        end else begin
            rgb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_changed) begin
                        hue_sh <= hue;
                        sat_sh <= saturation;
                        val_sh <= value;
                        state  <= CLAMP;
                    end
                end
                CLAMP: begin
                    region <= region_w;
                    rem    <= rem_w;
                    sat_c  <= s_w;
                    val_c  <= v_w;
                    state  <= SCALE;
                end
                SCALE: begin
                    vmax  <= vmax_w;
                    state <= SPAN;
                end
                SPAN: begin
                    vmin  <= vmin_w;
                    up    <= up_w;
                    dn    <= dn_w;
                    state <= MIX;
                end
                MIX: begin
`ifdef HSV_GAMMA_EN
                    lin_r <= mix_r_w;
                    lin_g <= mix_g_w;
                    lin_b <= mix_b_w;
                    state <= GAMMA;
`else
                    red       <= mix_r_w;
                    green     <= mix_g_w;
                    blue      <= mix_b_w;
                    rgb_valid <= 1'b1;
                    state     <= IDLE;
`endif
                end
                GAMMA: begin
`ifdef HSV_GAMMA_EN
                    red       <= gamma8(lin_r);
                    green     <= gamma8(lin_g);
                    blue      <= gamma8(lin_b);
                    rgb_valid <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       pwm_cnt;
    logic             pwm_tick;
    logic             pwm_wrap;

    assign pwm_tick = (div_cnt == '0);
    assign pwm_wrap = pwm_tick && (pwm_cnt == 8'(PWM_TOP));

    // Prescaler down-counter and the shared 0..254 PWM ramp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= DIV_W'(PWM_DIV - 1);
            pwm_cnt <= 8'd0;
        end else if (pwm_tick) begin
            div_cnt <= DIV_W'(PWM_DIV - 1);
            pwm_cnt <= pwm_wrap ? 8'd0 : (pwm_cnt + 8'd1);
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    rgb_pwm_channel u_ch_r (
        .clk   (clk),
        .reset (reset),
        .duty  (red),
        .load  (rgb_valid),
        .wrap  (pwm_wrap),
        .cnt   (pwm_cnt),
        .led   (led_r)
    );

    rgb_pwm_channel u_ch_g (
        .clk   (clk),
        .reset (reset),
        .duty  (green),
        .load  (rgb_valid),
        .wrap  (pwm_wrap),
        .cnt   (pwm_cnt),
        .led   (led_g)
    );

    rgb_pwm_channel u_ch_b (
        .clk   (clk),
        .reset (reset),
        .duty  (blue),
        .load  (rgb_valid),
        .wrap  (pwm_wrap),
        .cnt   (pwm_cnt),
        .led   (led_b)
    );

endmodule

// File: tb/tb_hsv_rgb_pwm.sv
// Bench for hsv_rgb_pwm: two instances (PWM_DIV=1 and 4) share stimulus; a behavioural
// model is compared every cycle, and directed vectors carry hand-computed values.
module tb_hsv_rgb_pwm;

`ifdef HSV_GAMMA_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int DIVS [2] = '{1, 4};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [8:0] hue = 9'd0;
    logic [8:0] saturation = 9'd0;
    logic [8:0] value = 9'd0;

    logic [1:0][7:0] red_o;
    logic [1:0][7:0] green_o;
    logic [1:0][7:0] blue_o;
    logic [1:0] vld_o;
    logic [1:0] busy_o;
    logic [1:0] led_r_o;
    logic [1:0] led_g_o;
    logic [1:0] led_b_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hsv_rgb_pwm #(.PWM_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .hue(hue), .saturation(saturation), .value(value),
        .red(red_o[0]), .green(green_o[0]), .blue(blue_o[0]), .rgb_valid(vld_o[0]),
        .busy(busy_o[0]), .led_r(led_r_o[0]), .led_g(led_g_o[0]), .led_b(led_b_o[0])
    );

    hsv_rgb_pwm #(.PWM_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .hue(hue), .saturation(saturation), .value(value),
        .red(red_o[1]), .green(green_o[1]), .blue(blue_o[1]), .rgb_valid(vld_o[1]),
        .busy(busy_o[1]), .led_r(led_r_o[1]), .led_g(led_g_o[1]), .led_b(led_b_o[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int gam(input int x);
`ifdef HSV_GAMMA_EN
        return (x * x) / 255;
`else
        return x;
`endif
    endfunction

    // Textbook HSV->RGB with integer percentages and truncating division.
    function automatic void hsv2rgb(input int hh, input int ss, input int vv,
                                    output int r, output int g, output int b);
        int hi, lo, f, sec;
        if (hh >= 360) hh -= 360;
        if (ss > 100) ss = 100;
        if (vv > 100) vv = 100;
        sec = hh / 60;
        hi  = vv * 255 / 100;
        lo  = hi * (100 - ss) / 100;
        f   = (hi - lo) * (hh % 60) / 60;
        case (sec)
            0: begin r = hi;     g = lo + f; b = lo;     end
            1: begin r = hi - f; g = hi;     b = lo;     end
            2: begin r = lo;     g = hi;     b = lo + f; end
            3: begin r = lo;     g = hi - f; b = hi;     end
            4: begin r = lo + f; g = lo;     b = hi;     end
            default: begin r = hi; g = lo;   b = hi - f; end
        endcase
        r = gam(r);
        g = gam(g);
        b = gam(b);
    endfunction

    // Model state: conversion outputs, countdown to result, shadows, PWM per instance.
    int m_r, m_g, m_b, m_left, sh_h, sh_s, sh_v;
    bit m_valid;
    int k [2];
    int pend [2][3];
    int act [2][3];

    always @(posedge clk or posedge reset) begin : model
        if (reset) begin
            m_r = 0; m_g = 0; m_b = 0; m_left = 0; m_valid = 0;
            sh_h = 0; sh_s = 0; sh_v = 0;
            for (int d = 0; d < 2; d++) begin
                k[d] = 0;
                for (int c = 0; c < 3; c++) begin
                    pend[d][c] = 0;
                    act[d][c] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                k[d]++;
                if (k[d] % (255 * DIVS[d]) == 0) begin
                    for (int c = 0; c < 3; c++) act[d][c] = pend[d][c];
                end
                if (m_valid) begin
                    pend[d][0] = m_r;
                    pend[d][1] = m_g;
                    pend[d][2] = m_b;
                end
            end
            m_valid = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    hsv2rgb(sh_h, sh_s, sh_v, m_r, m_g, m_b);
                    m_valid = 1;
                end
            end else if (int'(hue) != sh_h || int'(saturation) != sh_s || int'(value) != sh_v) begin
                sh_h = int'(hue);
                sh_s = int'(saturation);
                sh_v = int'(value);
                m_left = LAT;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int cnt;
            cnt = (k[d] / DIVS[d]) % 255;
            chk($sformatf("red[%0d]", d), int'(red_o[d]), m_r);
            chk($sformatf("green[%0d]", d), int'(green_o[d]), m_g);
            chk($sformatf("blue[%0d]", d), int'(blue_o[d]), m_b);
            chk($sformatf("rgb_valid[%0d]", d), int'(vld_o[d]), int'(m_valid));
            chk($sformatf("busy[%0d]", d), int'(busy_o[d]), int'(m_left > 0));
            chk($sformatf("led_r[%0d]", d), int'(led_r_o[d]), int'(cnt < act[d][0]));
            chk($sformatf("led_g[%0d]", d), int'(led_g_o[d]), int'(cnt < act[d][1]));
            chk($sformatf("led_b[%0d]", d), int'(led_b_o[d]), int'(cnt < act[d][2]));
        end
    end

    task automatic drive(input int h, input int s, input int v);
        @(negedge clk);
        #1;
        hue = 9'(h);
        saturation = 9'(s);
        value = 9'(v);
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_o[0] && n < 40);
        if (!vld_o[0]) chk({nm, " timeout"}, 0, 1);
    endtask

    task automatic check_rgb(input string nm, input int er, input int eg, input int eb);
        chk({nm, " red"}, int'(red_o[0]), gam(er));
        chk({nm, " green"}, int'(green_o[0]), gam(eg));
        chk({nm, " blue"}, int'(blue_o[0]), gam(eb));
    endtask

    task automatic convert(input string nm, input int h, input int s, input int v,
                           input int er, input int eg, input int eb);
        int n;
        drive(h, s, v);
        wait_valid(nm, n);
        chk({nm, " latency"}, n - 1, LAT);
        check_rgb(nm, er, eg, eb);
    endtask

    // Counts LED high cycles over 1020 clocks: four periods at div 1, one at div 4.
    task automatic led_window(input string nm, input int er, input int eg, input int eb);
        int cr [2], cg [2], cb [2];
        repeat (2040) @(negedge clk);
        for (int d = 0; d < 2; d++) begin cr[d] = 0; cg[d] = 0; cb[d] = 0; end
        repeat (1020) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cr[d] += int'(led_r_o[d]);
                cg[d] += int'(led_g_o[d]);
                cb[d] += int'(led_b_o[d]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s led_r count[%0d]", nm, d), cr[d], 4 * gam(er));
            chk($sformatf("%s led_g count[%0d]", nm, d), cg[d], 4 * gam(eg));
            chk($sformatf("%s led_b count[%0d]", nm, d), cb[d], 4 * gam(eb));
        end
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset red", int'(red_o[0]), 0);
        chk("reset busy", int'(busy_o[0]), 0);
        chk("reset led_r", int'(led_r_o[1]), 0);
        #1 reset = 1'b0;

        convert("red", 0, 100, 100, 255, 0, 0);
        led_window("red", 255, 0, 0);
        convert("green", 120, 100, 100, 0, 255, 0);
        convert("orange", 30, 100, 100, 255, 127, 0);

        for (int h = 0; h < 360; h++) begin
            convert($sformatf("grey h=%0d", h), h, 0, 50, 127, 127, 127);
        end
        led_window("grey", 127, 127, 127);

        convert("clamp", 400, 150, 200, 255, 170, 0);

        // Hue changes just before edge 2 of a running conversion.
        drive(60, 100, 100);
        @(posedge clk);
        @(posedge clk);
        #1 hue = 9'd180;
        wait_valid("busy-old", n);
        chk("busy-old latency", n, LAT);
        check_rgb("busy-old", 255, 255, 0);
        wait_valid("busy-new", n);
        chk("busy-new latency", n, LAT + 1);
        check_rgb("busy-new", 0, 255, 255);

        // Reset while the FSM sits in SPAN.
        drive(240, 100, 100);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_rgb("abort", 0, 0, 0);
        chk("abort busy", int'(busy_o[0]), 0);
        repeat (8) begin
            @(negedge clk);
            chk("abort no valid", int'(vld_o[0]), 0);
        end
        #1 reset = 1'b0;
        wait_valid("post-reset", n);
        chk("post-reset latency", n - 1, LAT);
        check_rgb("post-reset", 0, 0, 255);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
